// File: rtl/attn_out_collector.sv
// Collects the attention output stream into a 128-entry single-port SRAM and
// tracks per-entry coverage. Once collection ends, it serves host readback.
module attn_out_collector #(
  parameter int DATA_W   = 128,
  parameter int ROWS     = 4,
  parameter int GROUPS   = 32,
  parameter int ADDR_W   = 7,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [1:0]        in_row,
  input  logic [4:0]        in_group,
  input  logic [DATA_W-1:0] in_data,
  input  logic              src_done,
  output logic              mem_ceb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              complete,
  output logic              dup_err,
  output logic              miss_err,
  output logic [7:0]        count
);

  localparam int unsigned DEPTH = ROWS * GROUPS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]          state;
  logic [DEPTH-1:0]    sb;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [READ_LAT-2:0] rd_pipe;

  logic [ADDR_W-1:0]   beat_addr;
  logic                accept;
  logic                is_new;
  logic [7:0]          count_next;
  logic                flush_go;
  logic                rd_fire;
  logic                restart;

  always_comb begin
    beat_addr  = {in_group, in_row};
    accept     = (state == S_COLLECT) && in_valid;
    is_new     = accept && !sb[beat_addr];
    count_next = count + 8'(is_new);
    flush_go   = (state == S_COLLECT) && (src_done || (count_next == 8'(DEPTH)));
    rd_fire    = (state == S_DONE) && rd_req;
    restart    = (state == S_IDLE || state == S_DONE) && start;
  end

  // Host reads drive the SRAM port combinationally; collection writes go
  // out of the registered beat one cycle after capture. They never overlap.
  always_comb begin
    mem_ceb  = rd_fire ? 1'b0 : ~wr_en_q;
    mem_web  = rd_fire ? 1'b1 : ~wr_en_q;
    mem_addr = rd_fire ? rd_addr : wr_addr_q;
    mem_din  = wr_data_q;
    busy     = (state == S_COLLECT) || (state == S_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sb        <= '0;
      count     <= '0;
      complete  <= 1'b0;
      dup_err   <= 1'b0;
      miss_err  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= beat_addr;
        wr_data_q <= in_data;
      end
      if (restart) begin
        sb       <= '0;
        count    <= '0;
        complete <= 1'b0;
        dup_err  <= 1'b0;
        miss_err <= 1'b0;
        state    <= S_COLLECT;
      end else begin
        case (state)
          S_COLLECT: begin
            if (accept) begin
              if (sb[beat_addr]) dup_err <= 1'b1;
              else               sb[beat_addr] <= 1'b1;
              count <= count_next;
            end
            if (flush_go) state <= S_FLUSH;
          end
          S_FLUSH: begin
            complete <= (count == 8'(DEPTH)) && !dup_err;
            miss_err <= (count < 8'(DEPTH));
            state    <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Read valid rides a READ_LAT-1 deep pipe, then rd_data captures mem_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (restart) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_pipe[0] <= rd_fire;
      for (int unsigned i = 1; i < READ_LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
      rd_valid <= rd_pipe[READ_LAT-2];
      if (rd_pipe[READ_LAT-2]) rd_data <= mem_dout;
    end
  end

endmodule

// File: tb/tb_attn_out_collector.sv
// Directed-sequence bench for attn_out_collector with randomized beat order and
// payloads, a behavioural SRAM, and a coverage/readback reference model.
module tb_attn_out_collector;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_row = '0;
  logic [4:0]   in_group = '0;
  logic [127:0] in_data = '0;
  logic         src_done = 1'b0;
  logic         mem_ceb, mem_web;
  logic [6:0]   mem_addr;
  logic [127:0] mem_din;
  logic [127:0] mem_dout = '0;
  logic         rd_req = 1'b0;
  logic [6:0]   rd_addr = '0;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         busy, complete, dup_err, miss_err;
  logic [7:0]   count;

  attn_out_collector #(.DATA_W(128), .ROWS(4), .GROUPS(32), .ADDR_W(7), .READ_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_row(in_row),
    .in_group(in_group), .in_data(in_data), .src_done(src_done), .mem_ceb(mem_ceb),
    .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .complete(complete), .dup_err(dup_err), .miss_err(miss_err), .count(count)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with one-cycle read: dout updates on the edge sampling the read.
  logic [127:0] sram [128];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (!mem_ceb) begin
      if (!mem_web) begin
        sram[mem_addr] <= mem_din;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_dout <= sram[mem_addr];
      end
    end
  end

  logic [127:0] ref_mem [128];
  bit   [127:0] seen;
  int distinct, accepted, wr_base;
  bit dup, collecting;
  int tests = 0, fails = 0;
  int unsigned order [128];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic shuffle();
    for (int i = 0; i < 128; i++) order[i] = i;
    for (int i = 127; i > 0; i--) begin
      int j;
      int unsigned t;
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    collecting = 1; distinct = 0; accepted = 0; dup = 0; seen = '0;
    wr_base = wr_cnt;
    check("start_busy", busy, 1);
    check("start_count", count, 0);
    check("start_flags", {complete, dup_err, miss_err}, 0);
  endtask

  task automatic beat(input logic [6:0] a, input logic [127:0] d, input bit done);
    in_valid = 1'b1; in_group = a[6:2]; in_row = a[1:0]; in_data = d; src_done = done;
    tick();
    if (collecting) begin
      accepted++;
      ref_mem[a] = d;
      if (seen[a]) dup = 1;
      else begin seen[a] = 1'b1; distinct++; end
      if (done || distinct == 128) collecting = 0;
    end
    in_valid = 1'b0; src_done = 1'b0;
  endtask

  task automatic src_pulse();
    src_done = 1'b1;
    tick();
    src_done = 1'b0;
    collecting = 0;
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_count"}, count, 128'(distinct));
    check({tag, "_complete"}, complete, (distinct == 128 && !dup) ? 1 : 0);
    check({tag, "_dup_err"}, dup_err, dup ? 1 : 0);
    check({tag, "_miss_err"}, miss_err, (distinct < 128) ? 1 : 0);
    check({tag, "_writes"}, 128'(wr_cnt - wr_base), 128'(accepted));
  endtask

  task automatic read_burst(input string tag, input int first, input int n);
    rd_req = 1'b1; rd_addr = 7'(first);
    for (int j = 1; j <= n + 2; j++) begin
      int e;
      tick();
      e = j - 2;
      check({tag, "_rd_valid"}, rd_valid, (e >= 0 && e < n) ? 1 : 0);
      if (e >= 0 && e < n) check({tag, "_rd_data"}, rd_data, ref_mem[first + e]);
      rd_req = (j < n); rd_addr = 7'(first + j);
    end
    rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ceb_web"}, {mem_ceb, mem_web}, 2'b11);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_din"}, mem_din, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_flags"}, {busy, complete, dup_err, miss_err}, 0);
    check({tag, "_count"}, count, 0);
  endtask

  initial begin
    logic [127:0] dA, dB;
    int skip, nidle;
    for (int i = 0; i < 128; i++) begin sram[i] = '0; ref_mem[i] = '0; end

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    tick();

    // Reads in IDLE are ignored
    rd_req = 1'b1; rd_addr = 7'h10;
    nidle = 0;
    for (int j = 0; j < 4; j++) begin tick(); if (rd_valid !== 1'b0 || mem_ceb !== 1'b1) nidle++; end
    rd_req = 1'b0;
    check("idle_rd_ignored", 128'(nidle), 0);

    // 1: in-order beats, data = address in every lane, then a late src_done
    do_start();
    for (int a = 0; a < 128; a++) beat(7'(a), {4{32'(a)}}, 1'b0);
    src_pulse();
    finish_run("inorder");
    rd_req = 1'b1; rd_addr = 7'h45;
    tick();
    rd_req = 1'b0;
    check("rd45_not_yet", rd_valid, 0);
    tick();
    check("rd45_valid", rd_valid, 1);
    check("rd45_data", rd_data, {4{32'h45}});
    tick();
    check("rd45_drop", rd_valid, 0);
    check("rd45_hold", rd_data, {4{32'h45}});

    // 2: reverse order, random data, auto flush at 128 entries
    do_start();
    for (int a = 127; a >= 0; a--) beat(7'(a), rnd128(), 1'b0);
    finish_run("reverse");
    read_burst("reverse", 0, 128);

    // 3: entry 14 (g=3,r=2) written twice, one other entry missing
    do_start();
    skip = $urandom_range(127, 15);
    dA = rnd128(); dB = rnd128();
    beat(7'd14, dA, 1'b0);
    shuffle();
    for (int i = 0; i < 128; i++)
      if (order[i] != 14 && order[i] != skip) beat(7'(order[i]), rnd128(), 1'b0);
    beat(7'd14, dB, 1'b0);
    src_pulse();
    finish_run("dup");
    check("dup_count127", count, 127);
    read_burst("dup14", 14, 1);
    check("dup14_is_B", rd_data, dB);

    // 4: 100 distinct beats with src_done on the last; later beats not written
    do_start();
    shuffle();
    for (int i = 0; i < 100; i++) beat(7'(order[i]), rnd128(), i == 99);
    for (int i = 100; i < 105; i++) begin
      beat(7'(order[i]), rnd128(), 1'b0);
      check("post_done_ceb", mem_ceb, 1);
    end
    finish_run("partial");

    // 5: pipelined readback of addresses 0..7
    read_burst("burst8", 0, 8);

    // 6: reset mid-collection, then a full run
    do_start();
    shuffle();
    for (int i = 0; i < 50; i++) beat(7'(order[i]), rnd128(), 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    collecting = 0;
    #10 rst_n = 1'b1;
    tick();
    do_start();
    shuffle();
    for (int i = 0; i < 128; i++) beat(7'(order[i]), rnd128(), 1'b0);
    finish_run("after_reset");
    read_burst("after_reset", 120, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/attn_out_collector.md
Name: attn_out_collector

Overview:
Receiving end of the attention output stream (out_valid/out_row/out_group/out_data) driven by the 4x4 MHA attention pipeline. Captures every 128-bit result beat into a 128-entry single-port output SRAM at address {group,row}, tracks coverage with a per-entry scoreboard, and flags completion, duplicates or missing entries. After collection, serves host readback of the SRAM with fixed read latency, replacing the bench's direct fp_out sampling.

Parameters:
DATA_W, 128, beat width (4 lanes fp32)
ROWS, 4, rows per group (out_row range 0..3)
GROUPS, 32, groups (out_group range 0..31)
ADDR_W, 7, SRAM address width; ROWS*GROUPS = 2**ADDR_W = 128
READ_LAT, 2, SRAM read latency in cycles (rd_req to rd_valid)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear scoreboard/flags, begin collecting
in_valid  in  1  attention output beat valid (no backpressure)
in_row  in  2  beat row index
in_group  in  5  beat group index
in_data  in  DATA_W  beat payload
src_done  in  1  pulse: producer finished its stream
mem_ceb  out  1  SRAM chip enable, active low
mem_web  out  1  SRAM write enable, active low (0 = write)
mem_addr  out  ADDR_W  SRAM address
mem_din  out  DATA_W  SRAM write data
mem_dout  in  DATA_W  SRAM read data
rd_req  in  1  host read request (honoured only in DONE)
rd_addr  in  ADDR_W  host read address
rd_valid  out  1  readback data valid
rd_data  out  DATA_W  readback data
busy  out  1  high in COLLECT and FLUSH
complete  out  1  sticky: all 128 entries written exactly once
dup_err  out  1  sticky: a beat hit an already-written entry
miss_err  out  1  sticky: stream ended with unwritten entries
count  out  8  number of distinct entries written (0..128)

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_ceb=1, mem_web=1, mem_addr=0, mem_din=0; rd_valid=0, rd_data=0; busy=0, complete=0, dup_err=0, miss_err=0, count=0; scoreboard cleared; read pipeline flushed. SRAM contents untouched.
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE: start -> COLLECT. Other inputs ignored.
- COLLECT: each in_valid beat registered; on the next cycle write issued: mem_ceb=0, mem_web=0, mem_addr={in_group,in_row} (= group*4+row), mem_din=in_data. Write latency is exactly 1 cycle; back-to-back beats every cycle are sustained.
- Scoreboard: a bit already set -> dup_err=1, the SRAM is still overwritten, and count is unchanged. A bit not set -> set it and increment count.
- COLLECT -> FLUSH when src_done=1 or count reaches 128, evaluated including a beat accepted in the same cycle. Beats after that cycle are ignored.
- FLUSH (1 cycle): issues the pending write, if any. Then complete=(count==128 && !dup_err) and miss_err=(count<128), and the state moves to DONE.
- start while in COLLECT or FLUSH: ignored.
- DONE: rd_req -> mem_ceb=0, mem_web=1, mem_addr=rd_addr in the same cycle. rd_valid=1 with rd_data=mem_dout exactly READ_LAT cycles later. One read per cycle, fully pipelined. rd_data holds its value while rd_valid=0.
- rd_req outside DONE: ignored.
- start in DONE: clears scoreboard, count and all flags, drops in-flight read valids, and moves to COLLECT. A beat in that same cycle is not captured.
- Idle SRAM cycles: mem_ceb=1, mem_web=1.

Test Plan:
- 128 beats in order (group 0..31, row 0..3, data=addr replicated in 4 lanes), then src_done -> count=128, complete=1, no errors; readback of addr 0x45 gives rd_valid 2 cycles later with data 0x45 pattern.
- 128 beats in reverse order, one per cycle, no src_done -> auto FLUSH at count=128, then DONE with complete=1; all 128 readbacks match.
- Beat (g=3,r=2) sent twice with data A then B -> dup_err=1, count=127 after 128 beats, complete=0; rd_addr 14 returns B.
- 100 distinct beats, then src_done -> miss_err=1, count=100, complete=0; beats after src_done are not written (mem_ceb stays 1).
- rd_req every cycle for addr 0..7 in DONE -> rd_valid high for 8 consecutive cycles, starting 2 cycles after the first req, with correct data order; rd_req in IDLE -> no rd_valid.
- rst_n low mid-COLLECT after 50 beats -> all outputs at reset values immediately; start then a full 128-beat run -> complete=1.
